fg_pulse_generator: RTL and testbench
=====================================

Name: fg_pulse_generator

Overview:
- Synthesizable frame-grabber stimulus source: the transmit end of the fg_opto / fg_open signal pair that fsm_self_test consumes.
- Generates a periodic opto pulse (fg_opto) and a delayed shutter-open pulse (fg_open) with programmable period, open width and delay.
- Counts emitted frames.
- Used on-board for self-test loopback and bench replay in place of the behavioural generators.
- All timing is in clock cycles.

Parameters:
- CNT_W, 32, width of period/opened/delay inputs and internal phase counter.
- FRAME_W, 32, width of frame_counter.
- NUM_W, 16, width of num_frames.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  level; start request in IDLE, keep-running request in RUN
- fg_period  input  CNT_W  frame period in cycles
- fg_opened  input  CNT_W  width of fg_opto and fg_open pulses in cycles
- fg_delay  input  CNT_W  fg_open rising edge offset from fg_opto rising edge
- num_frames  input  NUM_W  frames to emit; 0 = continuous
- fg_opto  output  1  opto pulse
- fg_open  output  1  delayed open pulse
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse after the last frame of a bounded run
- cfg_error  output  1  sticky; set on rejected start
- frame_counter  output  FRAME_W  frames started since last accepted start

Behaviour:
- Reset state: state IDLE, phase=0, all outputs 0. Reset wins over every other event and aborts a run immediately; outputs are 0 the cycle after reset is sampled.
- States: IDLE, RUN, DONE.
- IDLE, enable=1 sampled, start check:
  - Latch period/opened/delay/num_frames.
  - Reject if fg_period<2, fg_opened==0, or fg_delay+fg_opened > fg_period. The sum is computed at CNT_W+1 bits, with no wrap.
  - Rejected: cfg_error<=1, stay IDLE.
  - Accepted: cfg_error<=0, frame_counter<=0, phase<=0, go RUN.
- Latency: fg_opto is high on the first cycle after the accepting edge.
- Input changes during RUN are ignored; only the latched copies are used.
- RUN, combinational from registered phase:
  - fg_opto = (phase < opened).
  - fg_open = (phase >= delay) && (phase < delay+opened).
  - Outputs are registered; implementations may register the decode provided the cycle alignment above holds.
  - delay=0 makes fg_open identical to fg_opto.
  - delay+opened==period makes fg_open end on the last cycle of the frame.
- Phase counter: increments every cycle and wraps period-1 -> 0. Each frame is exactly period cycles.
- frame_counter: increments on every phase==0 cycle in RUN, including the first frame, so it reads 1 during frame 1. It saturates at all-ones and does not wrap.
- End of frame (phase==period-1):
  - Bounded run: if num_frames!=0 and frame_counter==num_frames, go DONE.
  - enable==0: go IDLE (graceful stop; the current frame always completes).
  - Otherwise: phase<=0, continue.
  - If both conditions hold, the bounded-run rule takes precedence and the block goes DONE.
- enable deassertion mid-frame has no effect until the frame ends.
- DONE: done=1 for exactly one cycle, then IDLE. fg_opto/fg_open are 0 in DONE.
- IDLE re-arm: a new start needs enable sampled high in IDLE. Enable held high after DONE therefore restarts one cycle later, in IDLE.
- busy=1 exactly while state==RUN.
- frame_counter holds its value in IDLE and DONE until the next accepted start.

Test Plan:
- Reset mid-run: reset asserted during fg_opto high -> next cycle fg_opto=fg_open=busy=0, frame_counter=0.
- Basic continuous run: period=10, opened=3, delay=2, num_frames=0, enable held:
  - fg_opto high cycles 1-3, 11-13, 21-23 after start.
  - fg_open high cycles 3-5, 13-15.
  - frame_counter = 1, 2, 3 at cycles 1, 11, 21.
- Bounded run: period=8, opened=2, delay=0, num_frames=3:
  - Exactly 3 opto pulses.
  - fg_open identical to fg_opto.
  - done pulses at cycle 25.
  - busy high cycles 1-24.
  - frame_counter=3 afterwards.
- Graceful stop: same settings as the basic continuous run, enable dropped at phase 4 of frame 2 -> frame 2 completes (busy through phase 9), no done pulse, then IDLE with frame_counter=2.
- Config rejection:
  - opened=0 -> cfg_error=1, busy stays 0, no pulses.
  - period=10, opened=4, delay=7 -> cfg_error=1.
  - A subsequent valid start clears cfg_error.
- Edge fit: period=10, opened=5, delay=5 -> fg_open high phases 5-9, fg_opto high phases 0-4; they never overlap and are continuous across the frame wrap.

Source files
------------

// File: rtl/fg_pulse_generator.sv
// Frame-grabber stimulus source: periodic fg_opto pulse plus a delayed fg_open pulse,
// with programmable period/width/delay, bounded or continuous frame count.
module fg_pulse_generator #(
  parameter int CNT_W   = 32,
  parameter int FRAME_W = 32,
  parameter int NUM_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [CNT_W-1:0]   fg_period,
  input  logic [CNT_W-1:0]   fg_opened,
  input  logic [CNT_W-1:0]   fg_delay,
  input  logic [NUM_W-1:0]   num_frames,
  output logic               fg_opto,
  output logic               fg_open,
  output logic               busy,
  output logic               done,
  output logic               cfg_error,
  output logic [FRAME_W-1:0] frame_counter
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   opened_q, opened_d;
  logic [CNT_W-1:0]   delay_q, delay_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic               err_q, err_d;
  logic               opto_q, opto_d;
  logic               open_q, open_d;
  logic               done_q, done_d;

  logic [CNT_W:0]     start_sum;
  logic               start_bad;
  logic               frame_end;
  logic               last_frame;

  // Extra bit so a huge delay cannot wrap the sum into an accepted config
  assign start_sum  = {1'b0, fg_delay} + {1'b0, fg_opened};
  assign start_bad  = (fg_period < CNT_W'(2)) || (fg_opened == '0) ||
                      (start_sum > {1'b0, fg_period});
  assign frame_end  = (phase_q == period_q - CNT_W'(1));
  assign last_frame = (num_q != '0) && (fcnt_q == FRAME_W'(num_q));

  // Outputs are decoded from next-cycle values so the registered pulses line up
  // with the phase they describe.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    period_d = period_q;
    opened_d = opened_q;
    delay_d  = delay_q;
    num_d    = num_q;
    fcnt_d   = fcnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          period_d = fg_period;
          opened_d = fg_opened;
          delay_d  = fg_delay;
          num_d    = num_frames;
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            phase_d = '0;
            fcnt_d  = FRAME_W'(1);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (frame_end) begin
          phase_d = '0;
          if (last_frame) begin
            state_d = S_DONE;
          end else if (!enable) begin
            state_d = S_IDLE;
          end else if (fcnt_q != '1) begin
            fcnt_d = fcnt_q + FRAME_W'(1);
          end
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
    opto_d = (state_d == S_RUN) && (phase_d < opened_d);
    open_d = (state_d == S_RUN) && (phase_d >= delay_d) &&
             ({1'b0, phase_d} < ({1'b0, delay_d} + {1'b0, opened_d}));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      period_q <= '0;
      opened_q <= '0;
      delay_q  <= '0;
      num_q    <= '0;
      fcnt_q   <= '0;
      err_q    <= 1'b0;
      opto_q   <= 1'b0;
      open_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      opened_q <= opened_d;
      delay_q  <= delay_d;
      num_q    <= num_d;
      fcnt_q   <= fcnt_d;
      err_q    <= err_d;
      opto_q   <= opto_d;
      open_q   <= open_d;
      done_q   <= done_d;
    end
  end

  assign fg_opto       = opto_q;
  assign fg_open       = open_q;
  assign busy          = (state_q == S_RUN);
  assign done          = done_q;
  assign cfg_error     = err_q;
  assign frame_counter = fcnt_q;

endmodule

// File: tb/tb_fg_pulse_generator.sv
// Self-checking bench for fg_pulse_generator: per-cycle reference model, a config
// vector table, hand-written corner sequences and a randomized soak.
module tb_fg_pulse_generator;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] fg_period, fg_opened, fg_delay;
  logic [15:0] num_frames;
  logic        fg_opto, fg_open, busy, done, cfg_error;
  logic [31:0] frame_counter;

  always #5 clock = ~clock;

  fg_pulse_generator #(.CNT_W(32), .FRAME_W(32), .NUM_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .fg_period(fg_period), .fg_opened(fg_opened), .fg_delay(fg_delay),
    .num_frames(num_frames),
    .fg_opto(fg_opto), .fg_open(fg_open), .busy(busy), .done(done),
    .cfg_error(cfg_error), .frame_counter(frame_counter)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time since accepted start, frame = k/period, phase = k%period.
  int      m_mode = 0;             // 0 idle, 1 running, 2 done
  longint  m_k = 0, m_per = 0, m_op = 0, m_dl = 0, m_num = 0, m_fc = 0;
  logic    m_err = 1'b0;

  task automatic model_adv();
    if (reset) begin
      m_mode = 0; m_k = 0; m_fc = 0; m_err = 1'b0;
    end else begin
      case (m_mode)
        0: if (enable) begin
          m_per = fg_period; m_op = fg_opened; m_dl = fg_delay; m_num = num_frames;
          if (m_per < 2 || m_op == 0 || m_dl + m_op > m_per) m_err = 1'b1;
          else begin
            m_err = 1'b0; m_mode = 1; m_k = 0; m_fc = 1;
          end
        end
        1: if (m_k % m_per == m_per - 1) begin
          if (m_num != 0 && m_k / m_per + 1 == m_num) m_mode = 2;
          else if (!enable) m_mode = 0;
          else begin
            m_k++;
            m_fc = m_k / m_per + 1;
          end
        end else m_k++;
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic model_check();
    longint ph;
    logic e_opto, e_open;
    ph     = (m_mode == 1) ? m_k % m_per : 0;
    e_opto = (m_mode == 1) && (ph < m_op);
    e_open = (m_mode == 1) && (ph >= m_dl) && (ph < m_dl + m_op);
    chk("model_opto", fg_opto, e_opto);
    chk("model_open", fg_open, e_open);
    chk("model_busy", busy, m_mode == 1);
    chk("model_done", done, m_mode == 2);
    chk("model_cfg_error", cfg_error, m_err);
    chk("model_frame_counter", frame_counter, m_fc);
  endtask

  task automatic step();
    @(posedge clock);
    model_adv();
    #1;
    model_check();
  endtask

  task automatic cfg(input logic [31:0] p, input logic [31:0] o, input logic [31:0] d,
                     input logic [15:0] n);
    fg_period = p; fg_opened = o; fg_delay = d; num_frames = n;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] per, op, dl;
    logic [15:0] num;
    logic        err;
    int          pulses, dcyc, busyc;
    logic [31:0] fc;
  } vec_t;

  vec_t vt[10];

  initial begin
    int pulses, dcyc, busyc;
    logic prev;

    vt[0] = '{32'd8,   32'd2,  32'd0,         16'd3, 1'b0, 3, 25, 24, 32'd3};
    vt[1] = '{32'd10,  32'd3,  32'd2,         16'd2, 1'b0, 2, 21, 20, 32'd2};
    vt[2] = '{32'd10,  32'd5,  32'd5,         16'd1, 1'b0, 1, 11, 10, 32'd1};
    vt[3] = '{32'd2,   32'd1,  32'd1,         16'd2, 1'b0, 2, 5,  4,  32'd2};
    vt[4] = '{32'd2,   32'd2,  32'd0,         16'd1, 1'b0, 1, 3,  2,  32'd1};
    vt[5] = '{32'd10,  32'd0,  32'd2,         16'd1, 1'b1, 0, -1, 0,  32'd0};
    vt[6] = '{32'd10,  32'd4,  32'd7,         16'd1, 1'b1, 0, -1, 0,  32'd0};
    vt[7] = '{32'd1,   32'd1,  32'd0,         16'd1, 1'b1, 0, -1, 0,  32'd0};
    vt[8] = '{32'd5,   32'd3,  32'd3,         16'd1, 1'b1, 0, -1, 0,  32'd0};
    vt[9] = '{32'd100, 32'd10, 32'hFFFF_FFFF, 16'd1, 1'b1, 0, -1, 0,  32'd0};

    reset = 1'b1; enable = 1'b0;
    cfg(32'd10, 32'd3, 32'd2, 16'd0);

    // Reset state
    step();
    chk("reset_opto", fg_opto, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_fc", frame_counter, 32'd0);
    reset = 1'b0;

    // Basic continuous run
    enable = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      step();
      chk("basic_opto", fg_opto, (c <= 3) || (c >= 11 && c <= 13) || (c >= 21));
      chk("basic_open", fg_open, (c >= 3 && c <= 5) || (c >= 13 && c <= 15) || (c >= 23));
      if (c == 1 || c == 11 || c == 21) chk("basic_fc", frame_counter, c / 10 + 1);
    end

    // Reset mid-run while fg_opto is high
    do_reset();
    cfg(32'd10, 32'd3, 32'd2, 16'd0);
    enable = 1'b1;
    step(); step();
    chk("midrst_pre_opto", fg_opto, 1'b1);
    reset = 1'b1;
    step();
    chk("midrst_opto", fg_opto, 1'b0);
    chk("midrst_open", fg_open, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_fc", frame_counter, 32'd0);
    reset = 1'b0; enable = 1'b0;
    step();

    // Graceful stop: enable dropped at phase 4 of frame 2
    do_reset();
    cfg(32'd10, 32'd3, 32'd2, 16'd0);
    enable = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      chk("stop_busy", busy, c <= 20);
      chk("stop_done", done, 1'b0);
      if (c == 15) enable = 1'b0;
    end
    chk("stop_fc", frame_counter, 32'd2);

    // Config rejection, then a valid start clears cfg_error
    do_reset();
    cfg(32'd10, 32'd0, 32'd2, 16'd0);
    enable = 1'b1;
    step();
    chk("rej0_err", cfg_error, 1'b1);
    chk("rej0_busy", busy, 1'b0);
    repeat (3) begin
      step();
      chk("rej0_opto", fg_opto, 1'b0);
    end
    enable = 1'b0;
    step();
    cfg(32'd10, 32'd4, 32'd7, 16'd0);
    enable = 1'b1;
    step();
    chk("rej1_err", cfg_error, 1'b1);
    chk("rej1_busy", busy, 1'b0);
    cfg(32'd10, 32'd4, 32'd6, 16'd0);
    step();
    chk("accept_err", cfg_error, 1'b0);
    chk("accept_busy", busy, 1'b1);
    chk("accept_opto", fg_opto, 1'b1);
    enable = 1'b0;
    repeat (12) step();

    // Edge fit: open fills exactly the rest of each frame
    do_reset();
    cfg(32'd10, 32'd5, 32'd5, 16'd0);
    enable = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      chk("fit_overlap", fg_opto & fg_open, 1'b0);
      chk("fit_cover", fg_opto | fg_open, 1'b1);
    end
    enable = 1'b0;
    repeat (12) step();

    // Config vector table
    for (int i = 0; i < 10; i++) begin
      do_reset();
      cfg(vt[i].per, vt[i].op, vt[i].dl, vt[i].num);
      enable = 1'b1;
      prev = 1'b0; pulses = 0; dcyc = -1; busyc = 0;
      for (int c = 1; c <= 60; c++) begin
        step();
        if (fg_opto && !prev) pulses++;
        prev = fg_opto;
        if (busy) busyc++;
        if (done) begin
          dcyc = c;
          break;
        end
      end
      enable = 1'b0;
      step(); step();
      chk($sformatf("vec%0d_err", i), cfg_error, vt[i].err);
      chk($sformatf("vec%0d_pulses", i), pulses, vt[i].pulses);
      chk($sformatf("vec%0d_done_cycle", i), dcyc, vt[i].dcyc);
      chk($sformatf("vec%0d_busy_cycles", i), busyc, vt[i].busyc);
      chk($sformatf("vec%0d_fc", i), frame_counter, vt[i].fc);
    end

    // Randomized soak against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      if ($urandom_range(0, 4) == 0) begin
        fg_period  = $urandom_range(1, 12);
        fg_opened  = $urandom_range(0, fg_period);
        fg_delay   = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, fg_period);
        num_frames = 16'($urandom_range(0, 3));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
